// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the total-period helper.
package vga_timing_pkg;

   localparam int default_clk_mhz       = 50;
   localparam int default_pixel_mhz     = 25;
   localparam int default_screen_width  = 640;
   localparam int default_screen_height = 480;
   localparam int default_h_front       = 16;
   localparam int default_h_sync        = 96;
   localparam int default_h_back        = 48;
   localparam int default_v_front       = 10;
   localparam int default_v_sync        = 2;
   localparam int default_v_back        = 33;

   // Works for both axes: visible + front porch + sync + back porch.
   function automatic int calc_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// Divides the system clock down to one-cycle pixel advance pulses (adv).
module pixel_strobe_gen
   import vga_timing_pkg::*;
#(
   parameter int ratio     = 2,
   parameter int ratio_rem = 0
) (
   input  logic clk,
   input  logic rst,
   output logic adv
);

   localparam int w_div = (ratio > 1) ? $clog2(ratio) : 1;

   generate
      if (ratio < 1 || ratio_rem != 0) begin : g_bad_ratio
         $error("pixel_strobe_gen: clk_mhz must be a non-zero integer multiple of pixel_mhz");
      end
   endgenerate

   logic [w_div-1:0] div_q;
   logic [w_div-1:0] div_d;

   // With ratio = 1 the divider is stuck at 0, so adv is high every cycle.
   assign adv = (div_q == w_div'(ratio - 1));

   always_comb begin
      div_d = adv ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster generator: pixel/line counters with registered, mutually coherent decode.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int clk_mhz          = default_clk_mhz,
   parameter int pixel_mhz        = default_pixel_mhz,
   parameter int screen_width     = default_screen_width,
   parameter int screen_height    = default_screen_height,
   parameter int h_front          = default_h_front,
   parameter int h_sync           = default_h_sync,
   parameter int h_back           = default_h_back,
   parameter int v_front          = default_v_front,
   parameter int v_sync           = default_v_sync,
   parameter int v_back           = default_v_back,
   parameter int sync_active_high = 0,
   parameter int w_x              = $clog2(screen_width),
   parameter int w_y              = $clog2(screen_height)
) (
   input  logic           clk,
   input  logic           rst,
   output logic           hsync,
   output logic           vsync,
   output logic           display_on,
   output logic [w_x-1:0] x,
   output logic [w_y-1:0] y,
   output logic           pixel_strobe,
   output logic           line_start,
   output logic           frame_start
);

   localparam int ratio     = clk_mhz / pixel_mhz;
   localparam int ratio_rem = clk_mhz % pixel_mhz;
   localparam int h_total   = calc_total(screen_width, h_front, h_sync, h_back);
   localparam int v_total   = calc_total(screen_height, v_front, v_sync, v_back);
   localparam int w_h       = $clog2(h_total);
   localparam int w_v       = $clog2(v_total);

   // One extra bit so a sync end equal to the total period cannot wrap to 0.
   localparam logic [w_h:0] h_vis_end = (w_h + 1)'(screen_width);
   localparam logic [w_h:0] hs_start  = (w_h + 1)'(screen_width + h_front);
   localparam logic [w_h:0] hs_end    = (w_h + 1)'(screen_width + h_front + h_sync);
   localparam logic [w_v:0] v_vis_end = (w_v + 1)'(screen_height);
   localparam logic [w_v:0] vs_start  = (w_v + 1)'(screen_height + v_front);
   localparam logic [w_v:0] vs_end    = (w_v + 1)'(screen_height + v_front + v_sync);
   localparam logic         sync_on   = (sync_active_high != 0);

   logic adv;

   pixel_strobe_gen #(
      .ratio     (ratio),
      .ratio_rem (ratio_rem)
   ) u_pixel_strobe_gen (
      .clk (clk),
      .rst (rst),
      .adv (adv)
   );

   logic [w_h-1:0] hcount_q, hcount_d, h_step;
   logic [w_v-1:0] vcount_q, vcount_d, v_step;
   logic           h_wrap, h_vis, v_vis;
   logic           hsync_q, hsync_d, vsync_q, vsync_d, display_q, display_d;
   logic [w_x-1:0] x_q, x_d;
   logic [w_y-1:0] y_q, y_d;
   logic           pstb_q, pstb_d, lstart_q, lstart_d, fstart_q, fstart_d;

   always_comb begin
      h_wrap = (hcount_q == w_h'(h_total - 1));
      h_step = h_wrap ? '0 : hcount_q + 1'b1;
      v_step = vcount_q;
      if (h_wrap) begin
         v_step = (vcount_q == w_v'(v_total - 1)) ? '0 : vcount_q + 1'b1;
      end
      h_vis = ({1'b0, h_step} < h_vis_end);
      v_vis = ({1'b0, v_step} < v_vis_end);

      hcount_d  = hcount_q;
      vcount_d  = vcount_q;
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      display_d = display_q;
      x_d       = x_q;
      y_d       = y_q;
      pstb_d    = 1'b0;
      lstart_d  = 1'b0;
      fstart_d  = 1'b0;

      // Decode the position the counters are about to take, so outputs never lag.
      if (adv) begin
         hcount_d  = h_step;
         vcount_d  = v_step;
         display_d = h_vis && v_vis;
         x_d       = h_vis ? w_x'(h_step) : '0;
         y_d       = v_vis ? w_y'(v_step) : '0;
         hsync_d   = (({1'b0, h_step} >= hs_start) && ({1'b0, h_step} < hs_end)) ? sync_on : ~sync_on;
         vsync_d   = (({1'b0, v_step} >= vs_start) && ({1'b0, v_step} < vs_end)) ? sync_on : ~sync_on;
         pstb_d    = 1'b1;
         lstart_d  = (h_step == '0);
         fstart_d  = (h_step == '0) && (v_step == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hcount_q  <= w_h'(h_total - 1);
         vcount_q  <= w_v'(v_total - 1);
         hsync_q   <= ~sync_on;
         vsync_q   <= ~sync_on;
         display_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         pstb_q    <= 1'b0;
         lstart_q  <= 1'b0;
         fstart_q  <= 1'b0;
      end else begin
         hcount_q  <= hcount_d;
         vcount_q  <= vcount_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         display_q <= display_d;
         x_q       <= x_d;
         y_q       <= y_d;
         pstb_q    <= pstb_d;
         lstart_q  <= lstart_d;
         fstart_q  <= fstart_d;
      end
   end

   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign display_on   = display_q;
   assign x            = x_q;
   assign y            = y_q;
   assign pixel_strobe = pstb_q;
   assign line_start   = lstart_q;
   assign frame_start  = fstart_q;

endmodule
